// File: rtl/fetch_control_unit.sv
// fetch_control_unit: IF-stage redirect sequencer (PCsrc/stall/kill) with return-address stack.
module fetch_control_unit #(
    parameter int KILL_CYCLES = 2,
    parameter int RAS_DEPTH   = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jump_req,
    input  logic             call_req,
    input  logic             branch_taken,
    input  logic             ret_req,
    input  logic [15:0]      link_addr,
    input  logic             load_use,
    input  logic             mem_busy,
    output logic [1:0]       PCsrc,
    output logic             stall,
    output logic             kill,
    output logic [15:0]      ReturnAddress,
    output logic             ras_overflow,
    output logic             ras_underflow,
    output logic [CNT_W-1:0] redirect_cnt
);
    localparam int AW = $clog2(RAS_DEPTH);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t           r_state, w_next;
    logic [2:0]       r_kill_cnt, w_kill_cnt_nxt;
    logic [15:0]      r_ras [RAS_DEPTH];
    logic [AW-1:0]    r_ptr, w_top;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_redirect_cnt;
    logic             r_ovf, r_unf;
    logic             w_accept, w_push, w_pop, w_full, w_empty;
    always_comb begin
        stall          = !reset && (mem_busy || load_use);
        kill           = !reset && r_state == FLUSH;
        w_accept       = !reset && !stall && r_state == RUN &&
                         (jump_req || call_req || branch_taken || ret_req);
        w_pop          = w_accept && ret_req;
        w_push         = w_accept && call_req && !ret_req && !branch_taken;
        PCsrc          = !w_accept ? 2'd0 : ret_req ? 2'd3 : branch_taken ? 2'd2 : 2'd1;
        w_full         = r_count == (AW+1)'(RAS_DEPTH);
        w_empty        = r_count == '0;
        w_top          = r_ptr - 1'b1;
        ReturnAddress  = w_empty ? 16'h0000 : r_ras[w_top];
        w_next         = r_state;
        w_kill_cnt_nxt = r_kill_cnt;
        if (w_accept) begin
            w_next         = FLUSH;
            w_kill_cnt_nxt = 3'(KILL_CYCLES);
        end else if (r_state == FLUSH && !stall) begin
            w_kill_cnt_nxt = r_kill_cnt - 3'd1;
            w_next         = r_kill_cnt == 3'd1 ? RUN : FLUSH;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RUN;
            r_kill_cnt     <= '0;
            r_ptr          <= '0;
            r_count        <= '0;
            r_ovf          <= 1'b0;
            r_unf          <= 1'b0;
            r_redirect_cnt <= '0;
        end else begin
            r_state        <= w_next;
            r_kill_cnt     <= w_kill_cnt_nxt;
            r_redirect_cnt <= r_redirect_cnt + CNT_W'(w_accept);
            r_ovf          <= r_ovf || (w_push && w_full);
            r_unf          <= r_unf || (w_pop && w_empty);
            // When full, r_ptr already addresses the oldest entry, so a push overwrites it.
            if (w_push) begin
                r_ptr   <= r_ptr + 1'b1;
                r_count <= w_full ? r_count : r_count + 1'b1;
            end else if (w_pop && !w_empty) begin
                r_ptr   <= w_top;
                r_count <= r_count - 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_ras[r_ptr] <= link_addr;
    end
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;
    assign redirect_cnt  = r_redirect_cnt;
endmodule

// File: tb/tb_fetch_control_unit.sv
// tb_fetch_control_unit: directed checks of redirect sequencing, hazards, RAS and reset.
module tb_fetch_control_unit;
    logic        clk = 1'b0;
    logic        reset, jump_req, call_req, branch_taken, ret_req, load_use, mem_busy;
    logic [15:0] link_addr;
    logic [1:0]  PCsrc;
    logic        stall, kill, ras_overflow, ras_underflow;
    logic [15:0] ReturnAddress;
    logic [15:0] redirect_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    fetch_control_unit dut (
        .clk(clk), .reset(reset), .jump_req(jump_req), .call_req(call_req),
        .branch_taken(branch_taken), .ret_req(ret_req), .link_addr(link_addr),
        .load_use(load_use), .mem_busy(mem_busy), .PCsrc(PCsrc), .stall(stall),
        .kill(kill), .ReturnAddress(ReturnAddress), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clr();
        {jump_req, call_req, branch_taken, ret_req} = '0;
    endtask

    initial begin
        reset = 1'b1; load_use = 1'b0; mem_busy = 1'b1; link_addr = '0; clr();
        jump_req = 1'b1;
        cyc(); cyc();
        at_neg();
        chk("rst_pcsrc", 32'(PCsrc), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_kill", 32'(kill), 0);
        cyc();
        reset = 1'b0; mem_busy = 1'b0; clr();
        at_neg();
        chk("idle_pcsrc", 32'(PCsrc), 0);
        chk("idle_ra", 32'(ReturnAddress), 0);
        chk("idle_cnt", 32'(redirect_cnt), 0);
        chk("idle_flags", {30'd0, ras_overflow, ras_underflow}, 0);

        // 1: jump, then two kill cycles; a request during FLUSH is ignored
        cyc(); jump_req = 1'b1;
        at_neg();
        chk("j_pcsrc", 32'(PCsrc), 1);
        chk("j_kill0", 32'(kill), 0);
        cyc();
        at_neg();
        chk("j_kill1", 32'(kill), 1);
        chk("j_flush_pcsrc", 32'(PCsrc), 0);
        cyc(); clr();
        at_neg();
        chk("j_kill2", 32'(kill), 1);
        cyc();
        at_neg();
        chk("j_kill3", 32'(kill), 0);
        chk("j_cnt", 32'(redirect_cnt), 1);

        // 2: call then ret
        cyc(); call_req = 1'b1; link_addr = 16'h0010;
        at_neg();
        chk("c_pcsrc", 32'(PCsrc), 1);
        cyc(); clr(); cyc(); cyc();
        ret_req = 1'b1;
        at_neg();
        chk("r_ra", 32'(ReturnAddress), 32'h10);
        chk("r_pcsrc", 32'(PCsrc), 3);
        cyc(); clr();
        at_neg();
        chk("r_empty", 32'(ReturnAddress), 0);
        chk("r_cnt", 32'(redirect_cnt), 3);
        cyc(); cyc();

        // 3: overflow then drain to underflow
        for (int i = 1; i <= 5; i++) begin
            call_req = 1'b1; link_addr = 16'(2 * i);
            cyc(); clr(); cyc(); cyc();
        end
        at_neg();
        chk("ovf_flag", 32'(ras_overflow), 1);
        chk("ovf_top", 32'(ReturnAddress), 32'hA);
        cyc();
        for (int i = 0; i < 4; i++) begin
            ret_req = 1'b1;
            at_neg();
            chk("pop_ra", 32'(ReturnAddress), 32'(10 - 2 * i));
            cyc(); clr(); cyc(); cyc();
        end
        ret_req = 1'b1;
        at_neg();
        chk("unf_ra", 32'(ReturnAddress), 0);
        chk("unf_pcsrc", 32'(PCsrc), 3);
        chk("unf_flag_pre", 32'(ras_underflow), 0);
        cyc(); clr();
        at_neg();
        chk("unf_flag", 32'(ras_underflow), 1);
        chk("unf_cnt", 32'(redirect_cnt), 13);
        cyc(); cyc();

        // 4: branch held off by load-use
        branch_taken = 1'b1; load_use = 1'b1;
        at_neg();
        chk("lu_stall", 32'(stall), 1);
        chk("lu_pcsrc", 32'(PCsrc), 0);
        cyc(); load_use = 1'b0;
        at_neg();
        chk("b_pcsrc", 32'(PCsrc), 2);
        cyc(); clr();
        at_neg();
        chk("b_kill1", 32'(kill), 1);
        cyc();
        at_neg();
        chk("b_kill2", 32'(kill), 1);
        cyc();
        at_neg();
        chk("b_kill3", 32'(kill), 0);
        chk("b_cnt", 32'(redirect_cnt), 14);

        // 5: mem_busy freezes the flush count
        cyc(); jump_req = 1'b1;
        cyc(); clr(); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("mb_kill", 32'(kill), 1);
            chk("mb_stall", 32'(stall), 1);
            cyc();
        end
        mem_busy = 1'b0;
        at_neg();
        chk("mb_kill_a", 32'(kill), 1);
        cyc();
        at_neg();
        chk("mb_kill_b", 32'(kill), 1);
        cyc();
        at_neg();
        chk("mb_kill_end", 32'(kill), 0);
        chk("mb_cnt", 32'(redirect_cnt), 15);

        // call and ret together on an empty stack: ret wins, nothing pushed
        cyc(); call_req = 1'b1; ret_req = 1'b1; link_addr = 16'h0BEE;
        at_neg();
        chk("cr_pcsrc", 32'(PCsrc), 3);
        chk("cr_ra", 32'(ReturnAddress), 0);
        cyc(); clr();
        at_neg();
        chk("cr_nopush", 32'(ReturnAddress), 0);
        cyc(); cyc();

        // 6: reset in the middle of FLUSH with two stacked entries
        call_req = 1'b1; link_addr = 16'h0100;
        cyc(); clr(); cyc(); cyc();
        call_req = 1'b1; link_addr = 16'h0200;
        cyc(); clr(); cyc(); cyc();
        at_neg();
        chk("s6_top", 32'(ReturnAddress), 32'h200);
        jump_req = 1'b1;
        cyc(); clr();
        at_neg();
        chk("s6_flush", 32'(kill), 1);
        reset = 1'b1;
        at_neg();
        chk("s6_rst_kill", 32'(kill), 0);
        cyc(); reset = 1'b0;
        at_neg();
        chk("s6_kill", 32'(kill), 0);
        chk("s6_pcsrc", 32'(PCsrc), 0);
        chk("s6_ra", 32'(ReturnAddress), 0);
        chk("s6_cnt", 32'(redirect_cnt), 0);
        chk("s6_flags", {30'd0, ras_overflow, ras_underflow}, 0);
        cyc();
        at_neg();
        chk("s6_run", 32'(kill), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
